candidate_streamer: RTL and testbench
=====================================

# candidate_streamer

Transmit-side byte source for the `top_sha` hashing core. It latches one candidate password of up to `MAX_LEN` ASCII characters and streams it one byte per clock on the `byte_rdy`/`byte_stop`/data byte interface that `top_sha` consumes. It then holds end-of-message until the hash path signals completion or a timeout expires. It sits between the candidate generator and `top_sha` in the cracker datapath.

## Interface
- `MAX_LEN`, 8: maximum candidate length in bytes.
- `LEN_W`, 4: width of `cand_len`; must satisfy 2^`LEN_W` > `MAX_LEN`.
- `STOP_CYCLES`, 80: maximum number of cycles `byte_stop` is held without `hash_done`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  request to accept a candidate; sampled only in IDLE.
- `cand_data`  in  8*`MAX_LEN`  candidate characters, right-aligned like a Verilog string literal. Byte k (k = 0 … len-1) is `cand_data[8*(len-k)-1 -: 8]`.
- `cand_len`  in  `LEN_W`  number of valid characters, 1 … `MAX_LEN`.
- `hash_done`  in  1  completion pulse from the hash path; honoured only in STOP.
- `ready`  out  1  high in IDLE.
- `len_err`  out  1  one-cycle pulse when a load is rejected.
- `byte_rdy`  out  1  `byte_data` is valid this cycle; drives `top_sha` `byte_rdy`.
- `byte_stop`  out  1  end of message; drives `top_sha` `byte_stop`.
- `byte_data`  out  8  message byte; drives `top_sha` `data_in`.

## Operation
- **States:** IDLE, SEND, STOP.
- **IDLE**
  - `ready`=1.
  - On `load`=1 with 1 ≤ `cand_len` ≤ `MAX_LEN`: latch `cand_data` and `cand_len` into internal registers, clear the byte index, go to SEND.
  - On `load`=1 with `cand_len`=0 or `cand_len` > `MAX_LEN`: pulse `len_err` for 1 cycle and stay in IDLE.
- **SEND**
  - `byte_rdy`=1 and `byte_data` = latched byte[idx].
  - idx increments every cycle. There is no backpressure; the sink accepts a byte on every cycle `byte_rdy` is high.
  - After the byte with idx = len-1, go to STOP and clear the timeout counter.
- **STOP**
  - `byte_rdy`=0, `byte_stop`=1, `byte_data`=0.
  - Go to IDLE when `hash_done`=1 is sampled, or when the counter reaches `STOP_CYCLES`-1, whichever comes first.
  - Counter width is `$clog2(STOP_CYCLES+1)`. It saturates and never wraps.
- **Ignored inputs**
  - `load` in SEND or STOP is ignored, with no `len_err`.
  - `hash_done` in IDLE or SEND is ignored.
  - After a load is accepted, later changes on `cand_data`/`cand_len` have no effect on the message in flight.
- All outputs are registered.

## Timing
- **Reset values** (`rst` high at an edge; effective the following cycle): state=IDLE, `ready`=1, `len_err`=0, `byte_rdy`=0, `byte_stop`=0, `byte_data`=0, idx=0, counter=0.
- **Reset mid-message:** SEND or STOP aborts immediately with the values above. No partial `byte_stop` is emitted.
- **Load latency:**
  - Accepted load sampled at edge T → `ready`=0 and first byte on `byte_rdy`/`byte_data` in cycle T+1.
  - Byte k is presented in cycle T+1+k.
- **Stop:** `byte_stop` rises in cycle T+1+len, the cycle after the last byte. `byte_rdy` and `byte_stop` are never high together.
- **Stop hold:** `byte_stop` stays high for min(cycles until `hash_done` sampled, `STOP_CYCLES`) cycles, at least 1.
  - If `hash_done`=1 in the first STOP cycle, `byte_stop` is high for exactly 1 cycle.
- **Return to IDLE:** `ready`=1 in the cycle after STOP exits, and a new load is accepted there. The minimum load-to-load spacing is len+2 cycles.
- **Error pulse:** `len_err` is high in cycle T+1 only.

## Test plan
- **"abc":** load `cand_len`=3, `cand_data`=24'h616263 zero-extended → `byte_data` 61, 62, 63 in 3 consecutive cycles with `byte_rdy`=1, then `byte_stop`=1. Pulse `hash_done` 5 cycles later → `byte_stop` high exactly 5 cycles, then `ready`=1. The `top_sha` digest must equal ba7816bf…f20015ad.
- **Full length:** load "password" with `cand_len`=8 → 70 61 73 73 77 6f 72 64 on 8 consecutive cycles; `ready` low throughout.
- **Length errors:**
  - `cand_len`=0 → `len_err` pulses 1 cycle, `byte_rdy` stays 0, `ready` stays 1.
  - `cand_len`=9 → same response.
- **Timeout:** "a" with `hash_done` held low → `byte_stop` high exactly 80 cycles, then IDLE.
- **Busy load:** in SEND, assert `load` with a different candidate → the original byte stream is unchanged and no `len_err` is raised.
- **Reset mid-SEND:** assert `rst` during the 2nd byte of "abc" → next cycle all outputs at reset values, `ready`=1. A subsequent "abc" load streams correctly.

Source files
------------

// File: rtl/candidate_streamer_if.sv
// Byte-stream bundle between the candidate generator, candidate_streamer and top_sha.
// master is the streamer side; slave is the generator/hash-path side.
interface candidate_streamer_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
);
  logic                   load;
  logic [8*MAX_LEN-1:0]   cand_data;
  logic [LEN_W-1:0]       cand_len;
  logic                   hash_done;
  logic                   ready;
  logic                   len_err;
  logic                   byte_rdy;
  logic                   byte_stop;
  logic [7:0]             byte_data;

  modport master (
    input  load, cand_data, cand_len, hash_done,
    output ready, len_err, byte_rdy, byte_stop, byte_data
  );

  modport slave (
    output load, cand_data, cand_len, hash_done,
    input  ready, len_err, byte_rdy, byte_stop, byte_data
  );
endinterface

// File: rtl/candidate_streamer.sv
// Latches one candidate password and streams it byte-by-byte to top_sha,
// then holds byte_stop until hash_done or a timeout returns it to IDLE.
module candidate_streamer #(
  parameter int MAX_LEN     = 8,
  parameter int LEN_W       = 4,
  parameter int STOP_CYCLES = 80
) (
  input  logic                  clk,
  input  logic                  rst,
  candidate_streamer_if.master  bus
);
  localparam int CNT_W = $clog2(STOP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [8*MAX_LEN-1:0] data_r, data_s;
  logic [LEN_W-1:0]     len_r, len_s;
  logic [LEN_W-1:0]     idx_r, idx_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic                 ready_r, ready_s;
  logic                 len_err_r, len_err_s;
  logic                 byte_rdy_r, byte_rdy_s;
  logic                 byte_stop_r, byte_stop_s;
  logic [7:0]           byte_data_r, byte_data_s;
  logic                 len_ok_s;

  // Byte k of a right-aligned string of length len sits (len-1-k) bytes above bit 0.
  function automatic logic [7:0] get_byte(input logic [8*MAX_LEN-1:0] d,
                                          input logic [LEN_W-1:0]     len,
                                          input logic [LEN_W-1:0]     k);
    logic [LEN_W-1:0] pos;
    pos = len - k - LEN_W'(1);
    return 8'(d >> {pos, 3'b000});
  endfunction

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_s     = state_r;
    data_s      = data_r;
    len_s       = len_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    ready_s     = 1'b0;
    len_err_s   = 1'b0;
    byte_rdy_s  = 1'b0;
    byte_stop_s = 1'b0;
    byte_data_s = 8'h00;
    len_ok_s    = (bus.cand_len != {LEN_W{1'b0}}) && (bus.cand_len <= LEN_W'(MAX_LEN));
    case (state_r)
      IDLE: begin
        if (bus.load && len_ok_s) begin
          state_s     = SEND;
          data_s      = bus.cand_data;
          len_s       = bus.cand_len;
          idx_s       = {LEN_W{1'b0}};
          byte_rdy_s  = 1'b1;
          byte_data_s = get_byte(bus.cand_data, bus.cand_len, {LEN_W{1'b0}});
        end else if (bus.load) begin
          ready_s   = 1'b1;
          len_err_s = 1'b1;
        end else begin
          ready_s = 1'b1;
        end
      end
      SEND: begin
        if (idx_r == len_r - LEN_W'(1)) begin
          state_s     = STOP;
          cnt_s       = {CNT_W{1'b0}};
          byte_stop_s = 1'b1;
        end else begin
          idx_s       = idx_r + LEN_W'(1);
          byte_rdy_s  = 1'b1;
          byte_data_s = get_byte(data_r, len_r, idx_r + LEN_W'(1));
        end
      end
      STOP: begin
        if (bus.hash_done || (cnt_r == CNT_W'(STOP_CYCLES - 1))) begin
          state_s = IDLE;
          ready_s = 1'b1;
        end else begin
          byte_stop_s = 1'b1;
          if (cnt_r == {CNT_W{1'b1}}) begin
            cnt_s = cnt_r;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
      end
      default: begin
        state_s = IDLE;
        ready_s = 1'b1;
      end
    endcase
  end

  // State, payload and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      data_r      <= {(8*MAX_LEN){1'b0}};
      len_r       <= {LEN_W{1'b0}};
      idx_r       <= {LEN_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ready_r     <= 1'b1;
      len_err_r   <= 1'b0;
      byte_rdy_r  <= 1'b0;
      byte_stop_r <= 1'b0;
      byte_data_r <= 8'h00;
    end else begin
      state_r     <= state_s;
      data_r      <= data_s;
      len_r       <= len_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      ready_r     <= ready_s;
      len_err_r   <= len_err_s;
      byte_rdy_r  <= byte_rdy_s;
      byte_stop_r <= byte_stop_s;
      byte_data_r <= byte_data_s;
    end
  end

  assign bus.ready     = ready_r;
  assign bus.len_err   = len_err_r;
  assign bus.byte_rdy  = byte_rdy_r;
  assign bus.byte_stop = byte_stop_r;
  assign bus.byte_data = byte_data_r;
endmodule

// File: tb/tb_candidate_streamer.sv
// Scoreboard bench for candidate_streamer: stimulus queues expected events,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_candidate_streamer;
  localparam int STOP_CYCLES = 80;

  typedef enum int {EV_BYTE = 0, EV_STOP = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    logic       contig;
    int         len;
  } ev_t;
  typedef logic [7:0] bytes_t [8];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;
  logic prev_rdy  = 1'b0;
  logic prev_stop = 1'b0;
  int   stop_run  = 0;

  candidate_streamer_if #(.MAX_LEN(8), .LEN_W(4)) bus ();

  candidate_streamer #(.MAX_LEN(8), .LEN_W(4), .STOP_CYCLES(STOP_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input ev_kind_t kind, input logic [7:0] data, input logic contig, input int len);
    ev_t e;
    e.kind = kind; e.data = data; e.contig = contig; e.len = len;
    exp_q.push_back(e);
  endtask

  // Send one message; n_done = cycles byte_stop should stay high (hash_done unless == STOP_CYCLES).
  task automatic run_msg(input logic [63:0] d, input int len, input bytes_t exp_b,
                         input int n_done, input bit busy);
    for (int k = 0; k < len; k++) push(EV_BYTE, exp_b[k], (k != 0), 0);
    push(EV_STOP, 8'h00, 1'b1, n_done);
    bus.cand_data = d; bus.cand_len = 4'(len); bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int c = 1; c < len + n_done; c++) begin
      if (busy && c == 2) begin
        bus.load = 1'b1; bus.cand_data = 64'h0000_0000_0078_797a; bus.cand_len = 4'd3;
      end else if (busy && c == len + 1) begin
        bus.load = 1'b1; bus.cand_len = 4'd0;
      end else begin
        bus.load = 1'b0;
      end
      tick();
    end
    bus.load = 1'b0;
    if (n_done < STOP_CYCLES) bus.hash_done = 1'b1;
    tick();
    bus.hash_done = 1'b0;
    check("ready_after_stop", bus.ready, 1'b1);
  endtask

  task automatic bad_len(input logic [3:0] len);
    push(EV_ERR, 8'h00, 1'b0, 0);
    bus.cand_data = 64'h0000_0000_0061_6263; bus.cand_len = len; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("err_ready", bus.ready, 1'b1);
    check("err_byte_rdy", bus.byte_rdy, 1'b0);
    tick();
    check("err_ready_after", bus.ready, 1'b1);
  endtask

  // Monitor: every presented output must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (bus.len_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++; $display("FAIL unexpected_len_err actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        check("err_kind", 32'(mon_e.kind), 32'(EV_ERR));
      end
    end
    if (bus.byte_rdy === 1'b1) begin
      check("byte_with_stop", bus.byte_stop, 1'b0);
      check("byte_ready_low", bus.ready, 1'b0);
      if (exp_q.size() == 0) begin
        total++; bad++; $display("FAIL unexpected_byte actual=%0h required=none", bus.byte_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("byte_kind", 32'(mon_e.kind), 32'(EV_BYTE));
        check("byte_data", bus.byte_data, mon_e.data);
        check("byte_contig", prev_rdy, mon_e.contig);
      end
    end
    if (bus.byte_stop === 1'b1) begin
      if (!prev_stop) check("stop_after_last_byte", prev_rdy, 1'b1);
      check("stop_ready_low", bus.ready, 1'b0);
      stop_run = stop_run + 1;
    end else if (prev_stop) begin
      if (exp_q.size() == 0) begin
        total++; bad++; $display("FAIL unexpected_stop actual=%0d required=none", stop_run);
      end else begin
        mon_e = exp_q.pop_front();
        check("stop_kind", 32'(mon_e.kind), 32'(EV_STOP));
        check("stop_len", 32'(stop_run), 32'(mon_e.len));
      end
      check("ready_on_stop_exit", bus.ready, 1'b1);
      stop_run = 0;
    end
    prev_rdy  = (bus.byte_rdy === 1'b1);
    prev_stop = (bus.byte_stop === 1'b1);
  end

  initial begin
    bytes_t b_abc, b_pw, b_a, b_xy;
    b_abc = '{8'h61, 8'h62, 8'h63, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    b_pw  = '{8'h70, 8'h61, 8'h73, 8'h73, 8'h77, 8'h6f, 8'h72, 8'h64};
    b_a   = '{8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    b_xy  = '{8'h78, 8'h79, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bus.load = 1'b0; bus.cand_data = 64'h0; bus.cand_len = 4'd0; bus.hash_done = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", bus.ready, 1'b1);
    check("rst_len_err", bus.len_err, 1'b0);
    check("rst_byte_rdy", bus.byte_rdy, 1'b0);
    check("rst_byte_stop", bus.byte_stop, 1'b0);
    check("rst_byte_data", bus.byte_data, 8'h00);
    tick();

    run_msg(64'h0000_0000_0061_6263, 3, b_abc, 5, 1'b0);
    run_msg(64'h7061_7373_776f_7264, 8, b_pw, 3, 1'b1);
    bad_len(4'd0);
    bad_len(4'd9);
    run_msg(64'h0000_0000_0000_0061, 1, b_a, STOP_CYCLES, 1'b0);
    run_msg(64'h0000_0000_0000_7879, 2, b_xy, 1, 1'b0);

    // Reset lands during the second byte of "abc": only 61, 62 may appear.
    push(EV_BYTE, 8'h61, 1'b0, 0);
    push(EV_BYTE, 8'h62, 1'b1, 0);
    bus.cand_data = 64'h0000_0000_0061_6263; bus.cand_len = 4'd3; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", bus.ready, 1'b1);
    check("midrst_byte_rdy", bus.byte_rdy, 1'b0);
    check("midrst_byte_stop", bus.byte_stop, 1'b0);
    check("midrst_byte_data", bus.byte_data, 8'h00);
    check("midrst_len_err", bus.len_err, 1'b0);
    tick(); tick();
    run_msg(64'h0000_0000_0061_6263, 3, b_abc, 4, 1'b0);

    tick(); tick(); tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
